// File: rtl/aq_axi_ls_local_master.sv
// AXI4-Lite slave to AQ_LOCAL initiator bridge: one access in flight, write/read alternate on contention.
// Optional ACK watchdog enabled by defining AQ_LOCAL_TIMEOUT_EN (aborts with SLVERR after TIMEOUT cycles).
module aq_axi_ls_local_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        AQ_LOCAL_CLK,
  input  logic        RST_N,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic        AQ_LOCAL_CS,
  output logic        AQ_LOCAL_RNW,
  input  logic        AQ_LOCAL_ACK,
  output logic [31:0] AQ_LOCAL_ADDR,
  output logic [3:0]  AQ_LOCAL_BE,
  output logic [31:0] AQ_LOCAL_WDATA,
  input  logic [31:0] AQ_LOCAL_RDATA
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [3:0]  be_reg;
  logic [1:0]  resp_reg;
  logic        last_wr_reg;
  logic        wr_req, rd_req, grant_wr, grant_rd, in_acc, expire;

  assign wr_req = S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_req = S_AXI_ARVALID;
  // On contention the type not granted last wins; last_wr_reg resets to 0 so writes go first.
  assign grant_wr = RST_N & (state_reg == IDLE) & wr_req & (~rd_req | ~last_wr_reg);
  assign grant_rd = RST_N & (state_reg == IDLE) & rd_req & (~wr_req | last_wr_reg);
  assign in_acc   = (state_reg == WR_ACC) | (state_reg == RD_ACC);

`ifdef AQ_LOCAL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_reg;

  // ACK in the expiry cycle takes precedence, so expire requires ~ACK.
  assign expire = in_acc & ~AQ_LOCAL_ACK & (tmo_cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge AQ_LOCAL_CLK) begin
    if (!RST_N) begin
      tmo_cnt_reg <= 8'd0;
    end else if (grant_wr | grant_rd) begin
      tmo_cnt_reg <= 8'd0;
    end else if (in_acc & ~AQ_LOCAL_ACK) begin
      tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_wr)      state_next = WR_ACC;
        else if (grant_rd) state_next = RD_ACC;
      end
      WR_ACC:  if (AQ_LOCAL_ACK | expire) state_next = WR_RESP;
      WR_RESP: if (S_AXI_BREADY)          state_next = IDLE;
      RD_ACC:  if (AQ_LOCAL_ACK | expire) state_next = RD_RESP;
      RD_RESP: if (S_AXI_RREADY)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge AQ_LOCAL_CLK) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      rdata_reg   <= 32'd0;
      be_reg      <= 4'd0;
      resp_reg    <= RESP_OKAY;
      last_wr_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_wr) begin
        addr_reg    <= S_AXI_AWADDR;
        wdata_reg   <= S_AXI_WDATA;
        be_reg      <= S_AXI_WSTRB;
        last_wr_reg <= 1'b1;
      end else if (grant_rd) begin
        addr_reg    <= S_AXI_ARADDR;
        be_reg      <= 4'hF;
        last_wr_reg <= 1'b0;
      end
      if (in_acc & AQ_LOCAL_ACK) begin
        resp_reg <= RESP_OKAY;
        if (state_reg == RD_ACC) rdata_reg <= AQ_LOCAL_RDATA;
      end else if (expire) begin
        resp_reg <= RESP_SLVERR;
        if (state_reg == RD_ACC) rdata_reg <= 32'd0;
      end
    end
  end

  assign S_AXI_AWREADY  = grant_wr;
  assign S_AXI_WREADY   = grant_wr;
  assign S_AXI_ARREADY  = grant_rd;
  assign S_AXI_BVALID   = (state_reg == WR_RESP);
  assign S_AXI_BRESP    = resp_reg;
  assign S_AXI_RVALID   = (state_reg == RD_RESP);
  assign S_AXI_RRESP    = resp_reg;
  assign S_AXI_RDATA    = rdata_reg;
  assign AQ_LOCAL_CS    = in_acc;
  assign AQ_LOCAL_RNW   = (state_reg == RD_ACC);
  assign AQ_LOCAL_ADDR  = addr_reg;
  assign AQ_LOCAL_BE    = be_reg;
  assign AQ_LOCAL_WDATA = wdata_reg;

endmodule

// File: tb/tb_aq_axi_ls_local_master.sv
// Directed bench for aq_axi_ls_local_master: write/read timing, arbitration, back-pressure,
// ACK timeout (with or without AQ_LOCAL_TIMEOUT_EN) and mid-access reset.
module tb_aq_axi_ls_local_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        cs, rnw, ack;
  logic [31:0] addr, lwdata;
  logic [3:0]  be;
  logic [31:0] slave_rdata = '0;
  logic        ack_q = 1'b0;
  int          mode = 0;  // 0: ACK=CS, 1: registered ACK, 2: ACK tied low

  int errors = 0;
  int checks = 0;
  int cs_cycles = 0;
  int rd_resps = 0;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } acc_t;
  acc_t log_q[$];

  aq_axi_ls_local_master #(.TIMEOUT(16)) dut (
    .AQ_LOCAL_CLK  (clk),
    .RST_N         (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .AQ_LOCAL_CS   (cs),
    .AQ_LOCAL_RNW  (rnw),
    .AQ_LOCAL_ACK  (ack),
    .AQ_LOCAL_ADDR (addr),
    .AQ_LOCAL_BE   (be),
    .AQ_LOCAL_WDATA(lwdata),
    .AQ_LOCAL_RDATA(slave_rdata)
  );

  always #5 clk = ~clk;

  // Local slave model; the registered flavour repeats ACK one cycle after CS drops.
  assign ack = (mode == 0) ? cs : (mode == 1) ? ack_q : 1'b0;

  always @(posedge clk) begin
    ack_q <= cs;
    if (cs) cs_cycles <= cs_cycles + 1;
    if (rvalid && rready) rd_resps <= rd_resps + 1;
    if (rst_n && cs && ack) begin
      log_q.push_back('{rnw, addr, lwdata, be});
      $display("access %s addr=0x%08h wdata=0x%08h be=0x%h", rnw ? "RD" : "WR", addr, lwdata, be);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_base, rd_base, log_base;
    bit seen;
    logic expect_rnw [4];
    expect_rnw[0] = 1'b0; expect_rnw[1] = 1'b1; expect_rnw[2] = 1'b0; expect_rnw[3] = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_bvalid",  32'(bvalid), 0);
    check("rst_rvalid",  32'(rvalid), 0);
    check("rst_cs",      32'(cs), 0);
    check("rst_rnw",     32'(rnw), 0);
    check("rst_addr",    addr, 0);
    check("rst_be",      32'(be), 0);
    check("rst_wdata",   lwdata, 0);
    check("rst_rdata",   rdata, 0);
    check("rst_bresp",   32'(bresp), 0);
    check("rst_rresp",   32'(rresp), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, combinational slave
    mode = 0; cs_base = cs_cycles;
    awaddr = 32'h04; wdata = 32'h2EE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check("wr_awready", 32'(awready), 1);
    check("wr_wready",  32'(wready), 1);
    check("wr_arready", 32'(arready), 0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_cs_n1",   32'(cs), 1);
    check("wr_rnw",     32'(rnw), 0);
    check("wr_addr",    addr, 32'h04);
    check("wr_be",      32'(be), 32'hF);
    check("wr_wdata",   lwdata, 32'h2EE);
    check("wr_awready_n1", 32'(awready), 0);
    check("wr_bvalid_n1", 32'(bvalid), 0);
    @(negedge clk);
    check("wr_cs_n2",     32'(cs), 0);
    check("wr_bvalid_n2", 32'(bvalid), 1);
    check("wr_bresp",     32'(bresp), 0);
    check("wr_cs_cycles", 32'(cs_cycles - cs_base), 1);
    bready = 1'b1;
    @(negedge clk);
    check("wr_bvalid_done", 32'(bvalid), 0);
    bready = 1'b0;

    // Single read, registered slave
    mode = 1; slave_rdata = 32'h672; rd_base = rd_resps; log_base = log_q.size();
    araddr = 32'h08; arvalid = 1'b1;
    #1;
    check("rd_arready", 32'(arready), 1);
    check("rd_awready", 32'(awready), 0);
    @(negedge clk);
    arvalid = 1'b0;
    check("rd_cs_n1",  32'(cs), 1);
    check("rd_rnw",    32'(rnw), 1);
    check("rd_addr",   addr, 32'h08);
    check("rd_be",     32'(be), 32'hF);
    @(negedge clk);
    check("rd_cs_n2",     32'(cs), 1);
    check("rd_rvalid_n2", 32'(rvalid), 0);
    @(negedge clk);
    slave_rdata = 32'hDEAD_BEEF;
    check("rd_cs_n3",     32'(cs), 0);
    check("rd_rvalid_n3", 32'(rvalid), 1);
    check("rd_rdata",     rdata, 32'h672);
    check("rd_rresp",     32'(rresp), 0);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rd_rvalid_done", 32'(rvalid), 0);
    repeat (4) @(negedge clk);
    check("rd_single_resp",   32'(rd_resps - rd_base), 1);
    check("rd_single_access", 32'(log_q.size() - log_base), 1);
    check("rd_no_cs_after",   32'(cs), 0);

    // Contention: write and read requested together, twice
    mode = 0; bready = 1'b1; rready = 1'b1; log_base = log_q.size();
    awaddr = 32'h10; wdata = 32'h55; wstrb = 4'hF; araddr = 32'h14;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    for (int i = 0; i < 100 && (log_q.size() - log_base) < 4; i++) @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    repeat (3) @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("arb_count", 32'(log_q.size() - log_base), 4);
    for (int k = 0; k < 4; k++) begin
      if (log_base + k < log_q.size())
        check($sformatf("arb_order%0d", k), 32'(log_q[log_base + k].rnw), 32'(expect_rnw[k]));
    end

    // BREADY back-pressure with new requests pending
    mode = 0;
    awaddr = 32'h30; wdata = 32'h99; wstrb = 4'h5; araddr = 32'h34;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("bp_cs", 32'(cs), 1);
    check("bp_be", 32'(be), 32'h5);
    @(negedge clk);
    cs_base = cs_cycles;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_bvalid%0d", i),  32'(bvalid), 1);
      check($sformatf("bp_bresp%0d", i),   32'(bresp), 0);
      check($sformatf("bp_cs%0d", i),      32'(cs), 0);
      check($sformatf("bp_awready%0d", i), 32'(awready), 0);
      check($sformatf("bp_arready%0d", i), 32'(arready), 0);
      @(negedge clk);
    end
    check("bp_no_cs", 32'(cs_cycles - cs_base), 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    check("bp_bvalid_done", 32'(bvalid), 0);
    bready = 1'b0;

    // Read with ACK tied low
    mode = 2; araddr = 32'h40; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    cs_base = cs_cycles;
    check("tmo_cs_start", 32'(cs), 1);
`ifdef AQ_LOCAL_TIMEOUT_EN
    for (int i = 0; i < 100 && !rvalid; i++) @(negedge clk);
    check("tmo_rvalid",    32'(rvalid), 1);
    check("tmo_rresp",     32'(rresp), 32'h2);
    check("tmo_rdata",     rdata, 0);
    check("tmo_cs_cycles", 32'(cs_cycles - cs_base), 16);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    araddr = 32'h44; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
`else
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rvalid) seen = 1'b1;
    end
    check("notmo_no_rvalid", 32'(seen), 0);
`endif
    check("mid_cs_high", 32'(cs), 1);

    // Reset for one cycle while the read is outstanding
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_cs",     32'(cs), 0);
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_rnw",    32'(rnw), 0);
    check("mid_rst_rresp",  32'(rresp), 0);

    // Fresh write after reset
    mode = 0; bready = 1'b1;
    awaddr = 32'h20; wdata = 32'h1234; wstrb = 4'h3; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check("post_awready", 32'(awready), 1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("post_cs",    32'(cs), 1);
    check("post_addr",  addr, 32'h20);
    check("post_be",    32'(be), 32'h3);
    check("post_wdata", lwdata, 32'h1234);
    @(negedge clk);
    check("post_bvalid", 32'(bvalid), 1);
    check("post_bresp",  32'(bresp), 0);
    @(negedge clk);
    check("post_bvalid_done", 32'(bvalid), 0);
    bready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
